// File: rtl/receiver_uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the serial frame width and the receiver FSM state encoding.
// The receiver, its FIFO and a future transmitter can all use it.
package receiver_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/receiver_uart_fifo.sv
// Small synchronous FIFO with occupancy count.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data; ignored when full unless a pop happens in the same cycle
//   push_data   byte to store
//   pop         remove head; ignored when empty
//   full/empty  occupancy flags
//   head        entry at the read pointer (zero when empty)
//   count       current occupancy, 0..DEPTH
// DEPTH must be a power of 2 so that the pointers wrap naturally.
module receiver_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO is accepted.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];
  assign count   = cnt;

  // NOTE: the storage array has no reset; the count and pointers define which
  // entries are meaningful, and leaving the array unreset keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/receiver_uart.sv
// 8N1 UART receiver with a receive FIFO.
// RX is synchronised through two flops, a falling edge in IDLE starts a
// half-bit countdown, and every following baud tick samples one bit at
// mid-bit. Good bytes go into the FIFO; a bad stop bit raises o_frame_err.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_uart_rx      asynchronous serial line, idles high
//   o_data         FIFO head byte, meaningful while o_valid=1
//   o_valid        FIFO non-empty
//   i_ready        pop request; pops when o_valid && i_ready
//   o_count        FIFO occupancy
//   o_frame_err    one-cycle pulse on a stop bit sampled low
//   o_overrun      one-cycle pulse when a good byte is dropped on a full FIFO
module receiver_uart
  import receiver_uart_pkg::*;
#(
  parameter int clk_freq_hz = 12000000,
  parameter int baud_rate   = 115200,
  parameter int fifo_depth  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_uart_rx,
  output logic [UART_DATA_BITS-1:0]     o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(fifo_depth):0]   o_count,
  output logic                          o_frame_err,
  output logic                          o_overrun
);

  localparam int DIV  = clk_freq_hz / baud_rate;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam int BW   = $clog2(UART_DATA_BITS);

  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] BAUD_ONE = CW'(1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  rx_state_e                 state;
  logic                      rx_meta;
  logic                      rx_s;
  logic [CW-1:0]             baud_cnt;
  logic [BW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      tick;
  logic                      push;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign tick    = (baud_cnt == '0);
  // Push in the stop-bit tick cycle; the FIFO outputs follow on the next edge.
  assign push    = (state == ST_STOP) && tick && rx_s;
  assign o_valid = !fifo_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      rx_meta     <= i_uart_rx;
      rx_s        <= rx_meta;
      o_frame_err <= 1'b0;
      // When full, o_valid is high, so i_ready alone decides whether a slot frees up.
      o_overrun   <= push && fifo_full && !i_ready;
      baud_cnt    <= tick ? DIV_M1 : baud_cnt - BAUD_ONE;

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_START;
            baud_cnt <= HALF_M1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + BIT_ONE;
            if (bit_idx == BIT_LAST) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (rx_s) begin
              // Leave mid stop bit so a back-to-back start edge is not missed.
              state <= ST_IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          // A held-low line (break) gives one frame error, not one per frame time.
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  receiver_uart_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (shift),
    .pop       (i_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (o_data),
    .count     (o_count)
  );

endmodule
